// File: rtl/ram_sweep_pkg.sv
// ram_sweep_pkg: command opcodes and controller states shared by the sweep sequencer
package ram_sweep_pkg;
  typedef enum logic [1:0] {FILL_CONST = 2'd0, FILL_INC = 2'd1, DUMP = 2'd2, CHECK = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/ram_sweep_skid.sv
// ram_sweep_skid: 2-entry registered valid/ready buffer with occupancy output
module ram_sweep_skid #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic         pop;
  // head entry e0 drives the output; e1 only fills when e0 stays occupied
  always_comb begin
    pop   = cnt_q != 2'd0 && out_ready;
    cnt_d = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    e0_d  = pop ? (cnt_q == 2'd2 ? e1_q : in_data) : (cnt_q == 2'd0 && in_valid ? in_data : e0_q);
    e1_d  = in_valid && (cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop)) ? in_data : e1_q;
  end
  // buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = e0_q;
  assign count     = cnt_q;
endmodule

// File: rtl/ram_sweep_ctrl.sv
// ram_sweep_ctrl: fill / dump / checksum sequencer for a simple-dual-port RAM
module ram_sweep_ctrl
  import ram_sweep_pkg::*;
#(
  parameter int WID_MEM   = 18,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = $clog2(DEPTH_MEM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [ADDR_W:0]    cmd_len,
  input  logic [WID_MEM-1:0] cmd_data,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WID_MEM-1:0] out_data,
  output logic               out_last,
  output logic [WID_MEM-1:0] chk_xor,
  output logic [31:0]        chk_sum,
  output logic               busy,
  output logic               done
);
  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      cnt_q, cnt_d, len_q, len_d;
  logic [WID_MEM-1:0]   din_q, din_d, xor_q, xor_d;
  logic [31:0]          sum_q, sum_d;
  logic                 rv_q, rv_d, rl_q, rl_d;
  logic [1:0]           sk_cnt;
  logic [2:0]           occ;
  logic [WID_MEM:0]     sk_data;
  logic                 pop, room, last, issue;

  ram_sweep_skid #(.W(WID_MEM + 1)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rv_q && op_q == DUMP),
    .in_data  ({rl_q, mem_dout}),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (sk_data),
    .count    (sk_cnt)
  );

  // sequencing: a DUMP read may issue only if the buffer still has a slot once this cycle's pop and the in-flight return settle
  always_comb begin
    pop     = out_valid && out_ready;
    occ     = {1'b0, sk_cnt} + {2'b0, rv_q} - {2'b0, pop};
    room    = occ < 3'd2;
    last    = cnt_q == len_q - (ADDR_W + 1)'(1);
    issue   = state_q == READ && (op_q == CHECK || room);
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    din_d   = din_q;
    xor_d   = xor_q;
    sum_d   = sum_q;
    rv_d    = issue;
    rl_d    = issue && last;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = op_e'(cmd_op);
        len_d   = cmd_len;
        addr_d  = cmd_base;
        din_d   = cmd_data;
        cnt_d   = '0;
        xor_d   = op_e'(cmd_op) == CHECK ? '0 : xor_q;
        sum_d   = op_e'(cmd_op) == CHECK ? '0 : sum_q;
        state_d = cmd_len == '0 ? DONE : (cmd_op[1] ? READ : FILL);
      end
      FILL: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
        din_d   = op_q == FILL_INC ? din_q + WID_MEM'(1) : din_q;
        state_d = last ? DONE : FILL;
      end
      READ: if (issue) begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
        state_d = last ? DRAIN : READ;
      end
      DRAIN: state_d = op_q == CHECK || (pop && out_last) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (rv_q && op_q == CHECK) begin
      xor_d = xor_q ^ mem_dout;
      sum_d = sum_q + 32'(mem_dout);
    end
  end

  // controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= FILL_CONST;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      din_q   <= '0;
      xor_q   <= '0;
      sum_q   <= '0;
      rv_q    <= 1'b0;
      rl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      din_q   <= din_d;
      xor_q   <= xor_d;
      sum_q   <= sum_d;
      rv_q    <= rv_d;
      rl_q    <= rl_d;
    end
  end

  assign {out_last, out_data} = sk_data;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign mem_we    = state_q == FILL;
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_din   = din_q;
  assign chk_xor   = xor_q;
  assign chk_sum   = sum_q;
endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// tb_ram_sweep_ctrl: randomized self-checking bench with a behavioural RAM reference model
module tb_ram_sweep_ctrl;
  localparam int W = 18;
  localparam int D = 4096;
  localparam int A = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [A-1:0] cmd_base = '0;
  logic [A:0]   cmd_len = '0;
  logic [W-1:0] cmd_data = '0;
  logic [A-1:0] mem_raddr, mem_waddr;
  logic [W-1:0] mem_din, mem_dout, out_data, chk_xor;
  logic         mem_we, out_valid, out_last, busy, done;
  logic         out_ready = 1'b1;
  logic [31:0]  chk_sum;

  logic [W-1:0] mem [D] = '{default: '0};
  logic [W-1:0] ref_mem [D] = '{default: '0};
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_done = 0;
  logic [W-1:0] m_xor = '0;
  logic [31:0]  m_sum = '0;

  always #5 clk = ~clk;

  ram_sweep_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_data(cmd_data), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .chk_xor(chk_xor), .chk_sum(chk_sum), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_din;
    mem_dout <= mem[mem_raddr];
  end

  always @(negedge clk) if (done) n_done++;

  task automatic run_cmd(input logic [1:0] op, input logic [A-1:0] base, input logic [A:0] len,
                         input logic [W-1:0] data, input int pct, input int rst_n, input bit keep);
    logic [A-1:0] aq[$];
    logic [W-1:0] wq[$];
    logic [W-1:0] dq[$];
    logic [W-1:0] ex_xor, pd, v;
    logic [31:0]  ex_sum;
    bit           pv, pr, pl;
    int           c, dc, hs_c, ev, budget, exp_dc, a;
    c = 0;
    while (cmd_ready !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_wait got %b want 1", cmd_ready);
    end
    ex_xor = '0; ex_sum = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = (int'(base) + i) % D;
      v = op == 2'd1 ? W'(int'(data) + i) : data;
      if (op < 2'd2) begin
        aq.push_back(A'(a)); wq.push_back(v);
      end else begin
        if (op == 2'd2) dq.push_back(ref_mem[a]);
        ex_xor ^= ref_mem[a];
        ex_sum += 32'(ref_mem[a]);
      end
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len; cmd_data = data;
    @(posedge clk); #1;
    if (keep) cmd_op = 2'd3;
    else cmd_valid = 1'b0;
    dc = -1; hs_c = -1; ev = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    budget = 20 * int'(len) + 50;
    for (c = 1; c <= budget && dc < 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (mem_we) begin
        n_cmp++;
        if (aq.size() == 0) begin
          n_bad++; $display("FAIL unexpected_write addr %h data %h", mem_waddr, mem_din);
        end else begin
          if (mem_waddr !== aq[0] || mem_din !== wq[0]) begin
            n_bad++; $display("FAIL write got %h:%h want %h:%h", mem_waddr, mem_din, aq[0], wq[0]);
          end
          ref_mem[aq[0]] = wq[0];
          void'(aq.pop_front()); void'(wq.pop_front());
        end
        ev++;
      end
      if (pv && !pr) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          n_bad++; $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", out_valid, out_data, out_last, pd, pl);
        end
      end
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
        n_bad++; $display("FAIL busy_ready cycle %0d got %b want 0", c, cmd_ready);
      end
      if (done === 1'b1) dc = c;
      if (out_valid && op != 2'd2) begin
        n_cmp++; n_bad++; $display("FAIL stray_valid op %0d got 1 want 0", op);
      end
      out_ready = $urandom_range(99) < pct;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_bad++; $display("FAIL extra_word got %h want none", out_data);
        end else begin
          if (out_data !== dq[0] || out_last !== (dq.size() == 1)) begin
            n_bad++; $display("FAIL dump_word got %h/%b want %h/%b", out_data, out_last, dq[0], dq.size() == 1);
          end
          void'(dq.pop_front());
        end
        hs_c = c; ev++;
      end
      if (rst_n > 0 && ev >= rst_n) begin
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_last, mem_we, busy, done} !== 5'b0 || chk_xor !== '0 || chk_sum !== '0 || cmd_ready !== 1'b1) begin
          n_bad++; $display("FAIL mid_reset got v%b l%b we%b busy%b done%b x%h s%h want all 0, ready 1",
                            out_valid, out_last, mem_we, busy, done, chk_xor, chk_sum);
        end
        reset = 1'b0; cmd_valid = 1'b0; m_xor = '0; m_sum = '0; out_ready = 1'b1;
        return;
      end
    end
    exp_dc = len == '0 ? 1 : op < 2'd2 ? int'(len) + 1 : op == 2'd3 ? int'(len) + 2 : hs_c + 1;
    n_cmp++;
    if (dc != exp_dc) begin
      n_bad++; $display("FAIL done_cycle op %0d got %0d want %0d", op, dc, exp_dc);
    end
    n_cmp++;
    if (aq.size() != 0 || dq.size() != 0) begin
      n_bad++; $display("FAIL leftover got %0d writes %0d words want 0", aq.size(), dq.size());
    end
    if (op == 2'd3) begin
      m_xor = ex_xor; m_sum = ex_sum;
    end
    n_cmp++;
    if (chk_xor !== m_xor || chk_sum !== m_sum) begin
      n_bad++; $display("FAIL checksum got %h/%h want %h/%h", chk_xor, chk_sum, m_xor, m_sum);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL done_pulse got done%b busy%b ready%b want 0/0/1", done, busy, cmd_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_last, mem_we, busy, done} !== 5'b0 || cmd_ready !== 1'b1 || chk_xor !== '0 || chk_sum !== '0 ||
        out_data !== '0 || mem_raddr !== '0 || mem_waddr !== '0 || mem_din !== '0) begin
      n_bad++; $display("FAIL reset_state got v%b we%b busy%b done%b rdy%b x%h s%h want idle zeros",
                        out_valid, mem_we, busy, done, cmd_ready, chk_xor, chk_sum);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill_check;
    int n0;
    n0 = n_done;
    run_cmd(2'd1, 12'h000, 13'd4096, 18'h3FFF0, 100, 0, 0);
    run_cmd(2'd3, 12'h000, 13'd4096, 18'h0, 100, 0, 0);
    n_cmp++;
    if (n_done - n0 != 2) begin
      n_bad++; $display("FAIL done_count got %0d want 2", n_done - n0);
    end
    run_cmd(2'd2, 12'h000, 13'd4096, 18'h0, 100, 0, 0);
  endtask

  task automatic test_wrap;
    run_cmd(2'd0, 12'hFFE, 13'd4, 18'h15555, 100, 0, 0);
    run_cmd(2'd2, 12'hFFC, 13'd8, 18'h0, 100, 0, 0);
  endtask

  task automatic test_dump_stall;
    run_cmd(2'd2, 12'h010, 13'd8, 18'h0, 50, 0, 0);
    run_cmd(2'd2, 12'h010, 13'd8, 18'h0, 25, 0, 0);
    run_cmd(2'd2, 12'h7F0, 13'd33, 18'h0, 75, 0, 0);
  endtask

  task automatic test_zero_len;
    for (int op = 0; op < 4; op++) run_cmd(2'(op), A'($urandom), 13'd0, W'($urandom), 100, 0, 0);
  endtask

  task automatic test_busy;
    run_cmd(2'd1, 12'h100, 13'd10, 18'h2AAAA, 100, 0, 1);
    run_cmd(2'd3, 12'h100, 13'd10, 18'h2AAAA, 100, 0, 0);
  endtask

  task automatic test_reset_mid;
    run_cmd(2'd2, 12'h020, 13'd8, 18'h0, 60, 3, 0);
    run_cmd(2'd0, 12'h300, 13'd16, 18'h00001, 100, 5, 0);
    run_cmd(2'd3, 12'h300, 13'd16, 18'h0, 100, 0, 0);
    run_cmd(2'd2, 12'h2FC, 13'd24, 18'h0, 70, 0, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 30; k++)
      run_cmd(2'($urandom), A'($urandom), 13'($urandom_range(40)), W'($urandom), $urandom_range(20, 100), 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill_check();
    test_wrap();
    test_dump_stall();
    test_zero_len();
    test_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
